adc_spi_cfg: RTL
================

// Module: adc_spi_cfg
// PURPOSE
//  Power-up configuration sequencer for the dual-channel ADC serial port. Pulses adc_reset_out,
//  then writes a parameter-held table of 16-bit {addr,data} frames over SEN/SCLK/SDATA.
//  Afterwards it serves single register readbacks through a request/valid handshake.
//  Sits beside the ADC driver on the system clock.
//  cfg_done gates the downstream ADC->FIFO->DSP->DAC datapath enables.
// PARAMETERS
//  CLK_DIV      4       clk cycles per SCLK half-period (>=2); tick = 1-cycle pulse every CLK_DIV cycles
//  NUM_REGS     4       table entries written per configuration run (1..16)
//  CFG_TABLE    64'h... NUM_REGS*16 bits; entry i = CFG_TABLE[16*i+:16] = {addr[7:0],data[7:0]}, entry 0 first
//  RST_CYCLES   16      adc_reset_out high time, clk cycles
//  WAIT_CYCLES  64      delay from adc_reset_out fall to first SEN fall, clk cycles
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous active-high reset
//  start          in   1   pulse: re-run full sequence; accepted only in IDLE or DONE
//  rd_req         in   1   readback request; accepted only in DONE
//  rd_addr        in   8   register address, sampled on rd_req acceptance
//  rd_data        out  8   readback byte, valid with rd_valid, held until next readback
//  rd_valid       out  1   1-cycle pulse when rd_data is updated
//  busy           out  1   high in every state except IDLE and DONE
//  cfg_done       out  1   high in DONE only; cleared when a new run starts
//  adc_reset_out  out  1   ADC hardware reset, active high
//  adc_sen_out    out  1   serial enable, active low
//  adc_sclk_out   out  1   serial clock, idles low
//  adc_sdata_out  out  1   serial data, MSB first
//  adc_sdout_in   in   1   ADC serial readback data
// BEHAVIOUR
//  Reset values: adc_reset_out=0, adc_sen_out=1, adc_sclk_out=0, adc_sdata_out=0, busy=0, cfg_done=0,
//   rd_data=0, rd_valid=0. The FSM is in IDLE. rst high at any point aborts the frame and returns these values.
//  The first cycle after rst falls auto-starts a run (IDLE->RST_PULSE), exactly as a start pulse would.
//  FSM: IDLE -> RST_PULSE (RST_CYCLES, adc_reset_out=1) -> RST_WAIT (WAIT_CYCLES) -> LOAD -> SHIFT -> GAP.
//   From GAP: go to LOAD with idx+1 if idx<NUM_REGS-1, else go to DONE.
//  In DONE: start -> RST_PULSE; rd_req -> LOAD(read) -> SHIFT -> GAP -> DONE.
//  If start and rd_req arrive in the same DONE cycle, start wins and rd_req is dropped.
//  start/rd_req in any busy state are ignored; nothing is queued.
//  LOAD: 1 cycle; shift reg <= table entry idx, or {rd_addr,8'h00}; divider cleared; sen<=0; sdata<=frame[15].
//  SHIFT: 32 ticks. Odd ticks raise SCLK. Even ticks lower SCLK and present the next bit on sdata.
//   Setup to the rising edge is CLK_DIV cycles.
//   Read frame: on rising edges 9..16, sample adc_sdout_in into rd_data shift, MSB first.
//  GAP: after the 32nd tick, hold sen=0 one more tick, then sen=1. Stay in GAP for 2 ticks of sen=1 before the next LOAD.
//  Frame length, SEN fall to SEN rise: (33 ticks)*CLK_DIV + 1 clk cycles; SCLK period = 2*CLK_DIV.
//  rd_valid pulses on the cycle GAP->DONE after a read frame; rd_data updates on the same cycle.
//  Table writes never pulse rd_valid and never change rd_data.
//  idx counter width = clog2(NUM_REGS)+1. idx wraps to 0 on each new run.
//  NUM_REGS=1: exactly one frame, then DONE.
//  busy rises the cycle after start/auto-start and falls on the same cycle cfg_done rises.
// TESTING
//  1 Reset release, CLK_DIV=4, table {16'h0001,16'h4280} -> adc_reset_out high 16 cycles.
//    Then 64 idle cycles, then two frames; SDATA sampled on SCLK rise = 0x0001 then 0x4280.
//    cfg_done=1 after 2nd GAP.
//  2 SCLK timing check -> period 8 clk, 16 rising edges per frame, SEN high >=8 clk between frames, SCLK low while SEN high.
//  3 In DONE, rd_req with rd_addr=8'h42; model drives 8'hA5 on sdout (changes on SCLK fall).
//    Response: frame 0x4200 on SDATA, rd_valid 1-cycle pulse, rd_data=8'hA5, cfg_done high again.
//  4 start pulse mid-frame (busy=1) and rd_req in RST_WAIT -> both ignored, sequence and SDATA bits unchanged.
//  5 rst asserted at tick 10 of frame 1 -> next cycle all outputs at reset values.
//    After release, a full run restarts from entry 0 (reset pulse re-issued).
//  6 start and rd_req same cycle in DONE -> re-run starts (cfg_done=0, adc_reset_out=1), no rd_valid ever.

Source files
------------

// File: rtl/adc_spi_cfg_if.sv
// Readback handshake between a host and the ADC configuration sequencer.
// The host drives the request and address; the sequencer returns the byte and a valid strobe.
interface adc_spi_cfg_if;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (output rd_req, output rd_addr, input rd_data, input rd_valid);
    modport slave  (input rd_req, input rd_addr, output rd_data, output rd_valid);
endinterface

// File: rtl/adc_spi_cfg.sv
// ADC power-up sequencer: pulses the ADC reset, writes a {addr,data} table over SEN/SCLK/SDATA,
// then serves single-register readbacks.
module adc_spi_cfg #(
    parameter int unsigned             CLK_DIV     = 4,
    parameter int unsigned             NUM_REGS    = 4,
    parameter logic [NUM_REGS*16-1:0]  CFG_TABLE   = 64'h1234_5678_4280_0001,
    parameter int unsigned             RST_CYCLES  = 16,
    parameter int unsigned             WAIT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    adc_spi_cfg_if.slave      rd_if,
    output logic              busy,
    output logic              cfg_done,
    output logic              adc_reset_out,
    output logic              adc_sen_out,
    output logic              adc_sclk_out,
    output logic              adc_sdata_out,
    input  logic              adc_sdout_in
);

    localparam int unsigned DivW   = $clog2(CLK_DIV);
    localparam int unsigned IdxW   = $clog2(NUM_REGS) + 1;
    localparam int unsigned CntMax = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax) + 1;

    typedef enum logic [2:0] {
        StIdle, StRstPulse, StRstWait, StLoad, StShift, StGap, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [5:0]        tcnt_q, tcnt_d;
    logic [1:0]        gap_q, gap_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              is_rd_q, is_rd_d;
    logic [7:0]        addr_q, addr_d;
    logic [15:0]       shreg_q, shreg_d;
    logic              sen_q, sen_d, sclk_q, sclk_d, sdata_q, sdata_d;
    logic [7:0]        rsh_q, rsh_d, rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              tick;
    logic [15:0]       frame;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        is_rd_d    = is_rd_q;
        addr_d     = addr_q;
        shreg_d    = shreg_q;
        sen_d      = sen_q;
        sclk_d     = sclk_q;
        sdata_d    = sdata_q;
        rsh_d      = rsh_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        tick       = (div_q == DivW'(CLK_DIV - 1));
        div_d      = tick ? '0 : div_q + 1'b1;
        frame      = is_rd_q ? {addr_q, 8'h00} : CFG_TABLE[16*idx_q +: 16];

        unique case (state_q)
            StIdle: begin
                state_d = StRstPulse;
                cnt_d   = '0;
                idx_d   = '0;
                is_rd_d = 1'b0;
            end
            StRstPulse: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(RST_CYCLES - 1)) begin
                    state_d = StRstWait;
                    cnt_d   = '0;
                end
            end
            StRstWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WAIT_CYCLES - 1)) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                shreg_d = frame;
                div_d   = '0;
                tcnt_d  = '0;
                gap_d   = '0;
                sen_d   = 1'b0;
                sclk_d  = 1'b0;
                sdata_d = frame[15];
                state_d = StShift;
            end
            StShift: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 6'd1;
                    // Odd ticks (even count) raise SCLK; readback byte arrives on rises 9..16.
                    if (!tcnt_q[0]) begin
                        sclk_d = 1'b1;
                        if (is_rd_q && tcnt_q >= 6'd16) rsh_d = {rsh_q[6:0], adc_sdout_in};
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = shreg_q << 1;
                        sdata_d = shreg_q[14];
                    end
                    if (tcnt_q == 6'd31) state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q != 2'd0) sen_d = 1'b1;
                if (tick) begin
                    gap_d = gap_q + 2'd1;
                    if (gap_q == 2'd2) begin
                        if (is_rd_q) begin
                            state_d    = StDone;
                            rd_data_d  = rsh_q;
                            rd_valid_d = 1'b1;
                            is_rd_d    = 1'b0;
                        end else if (idx_q == IdxW'(NUM_REGS - 1)) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = StLoad;
                        end
                    end
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StRstPulse;
                    cnt_d   = '0;
                    idx_d   = '0;
                    is_rd_d = 1'b0;
                end else if (rd_if.rd_req) begin
                    state_d = StLoad;
                    is_rd_d = 1'b1;
                    addr_d  = rd_if.rd_addr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            tcnt_q     <= '0;
            gap_q      <= '0;
            idx_q      <= '0;
            is_rd_q    <= 1'b0;
            addr_q     <= '0;
            shreg_q    <= '0;
            sen_q      <= 1'b1;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            rsh_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            tcnt_q     <= tcnt_d;
            gap_q      <= gap_d;
            idx_q      <= idx_d;
            is_rd_q    <= is_rd_d;
            addr_q     <= addr_d;
            shreg_q    <= shreg_d;
            sen_q      <= sen_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            rsh_q      <= rsh_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign busy           = (state_q != StIdle) && (state_q != StDone);
    assign cfg_done       = (state_q == StDone);
    assign adc_reset_out  = (state_q == StRstPulse);
    assign adc_sen_out    = sen_q;
    assign adc_sclk_out   = sclk_q;
    assign adc_sdata_out  = sdata_q;
    assign rd_if.rd_data  = rd_data_q;
    assign rd_if.rd_valid = rd_valid_q;

endmodule
